spart_driver: RTL and testbench

- Bus master that configures and sequences the SPART through its iocs/iorw/ioaddr/databus interface.
- After reset it programs the baud divisor selected by br_cfg.
- It then runs an echo loop: it pulls received bytes into a small echo buffer and writes them back to the transmitter.
- It sits beside the SPART at top level, and is the SPART's only bus master.

---
 rtl/spart_pkg.sv | 28 ++
 rtl/spart_if.sv | 11 +
 rtl/spart_echo_fifo.sv | 62 ++++++
 rtl/spart_driver.sv | 149 ++++++++++++++
 tb/tb_spart_driver.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spart_pkg.sv
// Shared constants, state encoding and divisor helper for the SPART bus-master driver.
package spart_pkg;

  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  localparam int unsigned BAUD_4800  = 4800;
  localparam int unsigned BAUD_9600  = 9600;
  localparam int unsigned BAUD_19200 = 19200;
  localparam int unsigned BAUD_38400 = 38400;

  typedef enum logic [1:0] {CFG_LO, CFG_HI, RUN} state_e;

  // Divisor for 16x oversampling, truncated toward zero.
  function automatic logic [15:0] baud_div(input int unsigned clk_hz, input logic [1:0] sel);
    int unsigned baud;
    case (sel)
      2'd0:    baud = BAUD_4800;
      2'd1:    baud = BAUD_9600;
      2'd2:    baud = BAUD_19200;
      default: baud = BAUD_38400;
    endcase
    return 16'(clk_hz / (16 * baud) - 1);
  endfunction

endpackage

// File: rtl/spart_if.sv
// Control/handshake signals between the driver (master) and the SPART (slave).
interface spart_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (output iocs, iorw, ioaddr, input rda, tbr);
  modport slave  (input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_echo_fifo.sv
// Small synchronous FIFO holding received bytes until they are echoed back.
module spart_echo_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               wr_data,
  output logic [7:0]               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [AW:0] FULL_LVL = LW'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;

  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push && !full) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      level_d  = level_q + 1'b1;
    end else if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      level_d  = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; reset empties the FIFO by clearing pointers and level.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q] <= wr_data;
  end

  no_push_pop: assert property (@(posedge clk) disable iff (!rst) !(push && pop));

endmodule

// File: rtl/spart_driver.sv
// SPART bus master: programs the baud divisor from br_cfg, then echoes received bytes back.
module spart_driver
  import spart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100000000,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             br_cfg,
  spart_if.master                bus,
  inout  wire  [7:0]             databus,
  output logic                   cfg_done,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam logic [15:0] DIV_4800  = baud_div(CLK_HZ, 2'd0);
  localparam logic [15:0] DIV_9600  = baud_div(CLK_HZ, 2'd1);
  localparam logic [15:0] DIV_19200 = baud_div(CLK_HZ, 2'd2);
  localparam logic [15:0] DIV_38400 = baud_div(CLK_HZ, 2'd3);

  logic [1:0] br_meta_q, br_s_q;
  state_e     state_q, state_d;
  logic [1:0] cfg_sel_q, cfg_sel_d;
  logic       cfg_done_q, cfg_done_d;
  logic       iocs_q, iocs_d;
  logic       iorw_q, iorw_d;
  logic [1:0] ioaddr_q, ioaddr_d;
  logic [7:0] dout_q, dout_d;
  logic       rx_hold_q, rx_hold_d;
  logic       tx_hold_q, tx_hold_d;

  logic [1:0]  div_sel;
  logic [15:0] div_val;
  logic        push, pop, full, empty;
  logic [7:0]  rd_data;

  // Synchronizer carries no reset so br_s is already valid when reset lifts.
  always_ff @(posedge clk) begin
    br_meta_q <= br_cfg;
    br_s_q    <= br_meta_q;
  end

  always_comb begin
    div_sel = (state_q == CFG_LO) ? br_s_q : cfg_sel_q;
    unique case (div_sel)
      2'd0:    div_val = DIV_4800;
      2'd1:    div_val = DIV_9600;
      2'd2:    div_val = DIV_19200;
      default: div_val = DIV_38400;
    endcase
  end

  // A read completes (push) and a buffer write completes (pop) at the end of their access cycle.
  assign push = iocs_q & iorw_q;
  assign pop  = iocs_q & ~iorw_q & (ioaddr_q == ADDR_BUF);

  spart_echo_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (databus),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  always_comb begin
    state_d    = state_q;
    cfg_sel_d  = cfg_sel_q;
    cfg_done_d = cfg_done_q;
    iocs_d     = 1'b0;
    iorw_d     = 1'b1;
    ioaddr_d   = ADDR_BUF;
    dout_d     = dout_q;
    rx_hold_d  = 1'b0;
    tx_hold_d  = 1'b0;
    unique case (state_q)
      CFG_LO: begin
        iocs_d     = 1'b1;
        iorw_d     = 1'b0;
        ioaddr_d   = ADDR_DBL;
        dout_d     = div_val[7:0];
        cfg_sel_d  = br_s_q;
        cfg_done_d = 1'b0;
        state_d    = CFG_HI;
      end
      CFG_HI: begin
        iocs_d   = 1'b1;
        iorw_d   = 1'b0;
        ioaddr_d = ADDR_DBH;
        dout_d   = div_val[15:8];
        state_d  = RUN;
      end
      RUN: begin
        cfg_done_d = 1'b1;
        if (br_s_q != cfg_sel_q) begin
          cfg_done_d = 1'b0;
          state_d    = CFG_LO;
        end else if (bus.rda && !full && !rx_hold_q) begin
          iocs_d    = 1'b1;
          rx_hold_d = 1'b1;
        end else if (bus.tbr && !empty && !tx_hold_q) begin
          iocs_d    = 1'b1;
          iorw_d    = 1'b0;
          dout_d    = rd_data;
          tx_hold_d = 1'b1;
        end
      end
      default: state_d = CFG_LO;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= CFG_LO;
      cfg_sel_q  <= '0;
      cfg_done_q <= 1'b0;
      iocs_q     <= 1'b0;
      iorw_q     <= 1'b1;
      ioaddr_q   <= ADDR_BUF;
      dout_q     <= '0;
      rx_hold_q  <= 1'b0;
      tx_hold_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_sel_q  <= cfg_sel_d;
      cfg_done_q <= cfg_done_d;
      iocs_q     <= iocs_d;
      iorw_q     <= iorw_d;
      ioaddr_q   <= ioaddr_d;
      dout_q     <= dout_d;
      rx_hold_q  <= rx_hold_d;
      tx_hold_q  <= tx_hold_d;
    end
  end

  assign bus.iocs   = iocs_q;
  assign bus.iorw   = iorw_q;
  assign bus.ioaddr = ioaddr_q;
  assign cfg_done   = cfg_done_q;
  assign databus    = (iocs_q && !iorw_q) ? dout_q : 'z;

  // The driver relies on rda/tbr and never polls the status register.
  no_status_access: assert property (@(posedge clk) disable iff (!rst) ioaddr_q != ADDR_STAT);

endmodule

// File: tb/tb_spart_driver.sv
// Self-checking bench for spart_driver with a behavioural SPART model and write scoreboards.
module tb_spart_driver;

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
  } cfg_vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] br_cfg;
  logic       cfg_done;
  logic [2:0] fifo_level;
  wire  [7:0] databus;

  spart_if sif();

  logic       model_rda  = 1'b0;
  logic       model_tbr  = 1'b0;
  logic [7:0] spart_head = 8'h00;

  assign sif.rda = model_rda;
  assign sif.tbr = model_tbr;
  assign databus = (sif.iocs && sif.iorw) ? spart_head : 'z;

  spart_driver #(.CLK_HZ(100000000), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .br_cfg     (br_cfg),
    .bus        (sif.master),
    .databus    (databus),
    .cfg_done   (cfg_done),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_rd = 0;
  int n_wr = 0;
  logic prev_rd = 1'b0;
  logic prev_wr = 1'b0;

  cfg_vec_t   cfg_tab [4];
  logic [7:0] rx_q [$];
  logic [7:0] exp_data [$];
  logic [9:0] exp_cfg [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic add_rx(input logic [7:0] b);
    rx_q.push_back(b);
    exp_data.push_back(b);
  endtask

  task automatic expect_cfg(input logic [1:0] sel);
    exp_cfg.push_back({2'b10, cfg_tab[sel].lo});
    exp_cfg.push_back({2'b11, cfg_tab[sel].hi});
  endtask

  task automatic drain(input string name, input int max);
    int   k = 0;
    logic done;
    while ((rx_q.size() != 0 || exp_data.size() != 0 || exp_cfg.size() != 0 || fifo_level != 0) && k < max) begin
      cyc(1);
      k++;
    end
    done = (rx_q.size() == 0 && exp_data.size() == 0 && exp_cfg.size() == 0 && fifo_level == 0);
    chk(name, 32'(done), 32'd1);
  endtask

  task automatic wait_cfg_done(input logic val, input int max, input string name);
    int k = 0;
    while (cfg_done !== val && k < max) begin
      cyc(1);
      k++;
    end
    chk(name, 32'(cfg_done), 32'(val));
  endtask

  // Bus monitor and SPART model, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      prev_rd = 1'b0;
      prev_wr = 1'b0;
    end else begin
      if (sif.iocs && !sif.iorw) begin
        if (sif.ioaddr == 2'b00) begin
          chk("tx_after_tx", 32'(prev_wr), 32'd0);
          if (exp_data.size() == 0) fail("tx_unexpected", 32'(databus), 32'd0);
          else chk("tx_data", 32'(databus), 32'(exp_data.pop_front()));
          n_wr++;
        end else if (sif.ioaddr[1]) begin
          if (exp_cfg.size() == 0) fail("cfg_unexpected", 32'({sif.ioaddr, databus}), 32'd0);
          else chk("cfg_write", 32'({sif.ioaddr, databus}), 32'(exp_cfg.pop_front()));
        end else begin
          fail("status_write", 32'(sif.ioaddr), 32'd0);
        end
      end
      if (sif.iocs && sif.iorw) begin
        chk("rd_addr", 32'(sif.ioaddr), 32'd0);
        chk("rx_after_rx", 32'(prev_rd), 32'd0);
        if (rx_q.size() == 0) begin
          fail("rd_without_data", 32'd1, 32'd0);
        end else begin
          chk("rd_bus", 32'(databus), 32'(rx_q[0]));
          void'(rx_q.pop_front());
          n_rd++;
        end
      end
      prev_rd = sif.iocs && sif.iorw;
      prev_wr = sif.iocs && !sif.iorw && (sif.ioaddr == 2'b00);
    end
    if (!(sif.iocs && sif.iorw)) spart_head = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    model_rda = (rx_q.size() > 0);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   rd0, wr0;
    logic found;
    logic [1:0] ii, sel;

    cfg_tab[0] = '{lo: 8'h15, hi: 8'h05};
    cfg_tab[1] = '{lo: 8'h8A, hi: 8'h02};
    cfg_tab[2] = '{lo: 8'h44, hi: 8'h01};
    cfg_tab[3] = '{lo: 8'hA1, hi: 8'h00};

    rst = 1'b0;
    br_cfg = 2'b01;
    model_tbr = 1'b0;
    cyc(5);

    chk("rst_iocs", 32'(sif.iocs), 32'd0);
    chk("rst_iorw", 32'(sif.iorw), 32'd1);
    chk("rst_ioaddr", 32'(sif.ioaddr), 32'd0);
    chk("rst_cfg_done", 32'(cfg_done), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);

    // Reset release: two config writes then cfg_done.
    expect_cfg(2'b01);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("c1_iocs", 32'(sif.iocs), 32'd1);
    chk("c1_iorw", 32'(sif.iorw), 32'd0);
    chk("c1_addr", 32'(sif.ioaddr), 32'd2);
    chk("c1_data", 32'(databus), 32'h8A);
    @(posedge clk); #1;
    chk("c2_addr", 32'(sif.ioaddr), 32'd3);
    chk("c2_data", 32'(databus), 32'h02);
    chk("c2_cfg_done", 32'(cfg_done), 32'd0);
    @(posedge clk); #1;
    chk("c3_cfg_done", 32'(cfg_done), 32'd1);
    chk("c3_iocs", 32'(sif.iocs), 32'd0);
    cyc(5);
    chk("cfg_queue_empty", 32'(exp_cfg.size()), 32'd0);
    chk("no_extra_access", 32'(n_rd + n_wr), 32'd0);

    // Single byte echo.
    rd0 = n_rd; wr0 = n_wr;
    model_tbr = 1'b1;
    add_rx(8'h41);
    drain("echo_single_drain", 40);
    chk("echo_single_reads", 32'(n_rd - rd0), 32'd1);
    chk("echo_single_writes", 32'(n_wr - wr0), 32'd1);

    // Fill to full with tbr low; fifth byte must stay in the SPART.
    model_tbr = 1'b0;
    for (int i = 0; i < 5; i++) add_rx(8'h10 + 8'(i));
    cyc(30);
    chk("full_level", 32'(fifo_level), 32'd4);
    chk("full_fifth_held", 32'(rx_q.size()), 32'd1);
    chk("full_rda_still_high", 32'(model_rda), 32'd1);
    model_tbr = 1'b1;
    drain("full_drain", 80);

    // Baud change with two held bytes.
    model_tbr = 1'b0;
    add_rx(8'h61);
    add_rx(8'h62);
    cyc(12);
    chk("held_level", 32'(fifo_level), 32'd2);
    expect_cfg(2'b11);
    br_cfg = 2'b11;
    wait_cfg_done(1'b0, 10, "reconf_drop");
    wait_cfg_done(1'b1, 10, "reconf_done");
    chk("reconf_level_kept", 32'(fifo_level), 32'd2);
    chk("reconf_writes_seen", 32'(exp_cfg.size()), 32'd0);
    model_tbr = 1'b1;
    drain("reconf_drain", 40);

    // Table-driven sweep over every baud setting (order 0,2,1,3 so each step changes).
    for (int i = 0; i < 4; i++) begin
      ii  = 2'(i);
      sel = {ii[0], ii[1]};
      expect_cfg(sel);
      br_cfg = sel;
      wait_cfg_done(1'b0, 10, "sweep_drop");
      wait_cfg_done(1'b1, 10, "sweep_done");
      cyc(2);
      chk("sweep_writes_seen", 32'(exp_cfg.size()), 32'd0);
    end

    // Continuous rda and tbr: holds must separate same-direction accesses.
    rd0 = n_rd; wr0 = n_wr;
    model_tbr = 1'b1;
    for (int i = 0; i < 12; i++) add_rx(8'hC0 + 8'(i));
    drain("stream_drain", 200);
    chk("stream_writes", 32'(n_wr - wr0), 32'd12);
    chk("stream_reads", 32'(n_rd - rd0), 32'd12);

    // Reset in the middle of a buffer write.
    add_rx(8'h5C);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(posedge clk); #1;
      if (sif.iocs && !sif.iorw && sif.ioaddr == 2'b00) found = 1'b1;
    end
    chk("rst_found_write", 32'(found), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_iocs", 32'(sif.iocs), 32'd0);
    chk("arst_iorw", 32'(sif.iorw), 32'd1);
    chk("arst_level", 32'(fifo_level), 32'd0);
    chk("arst_cfg_done", 32'(cfg_done), 32'd0);
    exp_data.delete();
    rx_q.delete();
    cyc(3);
    expect_cfg(br_cfg);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("restart_addr", 32'(sif.ioaddr), 32'd2);
    chk("restart_data", 32'(databus), 32'(cfg_tab[br_cfg].lo));
    drain("restart_drain", 20);
    wait_cfg_done(1'b1, 10, "restart_done");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
